// File: rtl/irig_b_decoder.sv
// IRIG-B DC-level decoder: symbol width classification, frame sync and BCD time capture.
// Optional range check of the decoded time fields is enabled by defining IRIG_BCD_CHECK_EN.
module irig_b_decoder #(
    parameter int unsigned TH_1MS  = 125_000,
    parameter int unsigned TH_3MS  = 375_000,
    parameter int unsigned TH_4MS  = 500_000,
    parameter int unsigned TH_6MS  = 750_000,
    parameter int unsigned TH_7MS  = 875_000,
    parameter int unsigned TH_9MS  = 1_125_000,
    parameter int unsigned TO_12MS = 1_500_000
) (
    input  logic       pll_c0,
    input  logic       rst,
    input  logic       b_code_in,
    output logic       sym_valid,
    output logic [7:0] sym_code,
    output logic       locked,
    output logic       frame_valid,
    output logic [6:0] sec_bcd,
    output logic [6:0] min_bcd,
    output logic [5:0] hour_bcd,
    output logic [9:0] day_bcd,
    output logic [7:0] year_bcd,
    output logic       sync_err,
    output logic       bcd_err
);
    localparam logic [7:0] CODE_P = 8'h70;
    localparam logic [7:0] CODE_1 = 8'h31;
    localparam logic [7:0] CODE_0 = 8'h30;
    localparam logic [7:0] CODE_X = 8'h00;
    localparam int STAGES = 1;

    typedef struct packed {
        logic [6:0] sec;
        logic [6:0] min;
        logic [5:0] hour;
        logic [9:0] day;
        logic [7:0] year;
    } irig_time_t;

    typedef enum logic {HUNT, LOCKED} state_t;

    function automatic logic [7:0] classify(input logic [31:0] w);
        if (w >= TH_1MS && w <= TH_3MS)      return CODE_0;
        else if (w >= TH_4MS && w <= TH_6MS) return CODE_1;
        else if (w >= TH_7MS && w <= TH_9MS) return CODE_P;
        else                                 return CODE_X;
    endfunction

    logic              s1, s2, s3, rise, fall, to_hit;
    logic [31:0]       high_cnt, low_cnt, width_q;
    logic [STAGES:0]   vld_pipe, to_pipe;
    logic [7:0]        code_q;
    state_t            state, state_n;
    logic [6:0]        idx, idx_n, idx_nx;
    logic              prev_p, prev_p_n, sync_err_n, frame_done, cap_en, clr_sh;
    logic              ev_sym, ev_to, is_p, is_bit, marker, frame_ok;
    irig_time_t        shadow;

    always_comb begin
        rise   = s2 & ~s3;
        fall   = ~s2 & s3;
        // Fires only on the cycle a counter steps onto the limit, so saturation cannot re-trigger.
        to_hit = (s2 && !rise && high_cnt == TO_12MS - 32'd1) ||
                 (!s2 && !fall && low_cnt == TO_12MS - 32'd1);
    end

    always_ff @(posedge pll_c0) begin
        if (rst) begin
            {s1, s2, s3} <= '0;
            high_cnt     <= '0;
            low_cnt      <= '0;
            width_q      <= '0;
            vld_pipe     <= '0;
            to_pipe      <= '0;
            code_q       <= CODE_X;
        end else begin
            s1 <= b_code_in;
            s2 <= s1;
            s3 <= s2;
            if (rise)                          high_cnt <= 32'd1;
            else if (s2 && high_cnt != TO_12MS) high_cnt <= high_cnt + 32'd1;
            if (fall)                          low_cnt  <= 32'd1;
            else if (!s2 && low_cnt != TO_12MS) low_cnt  <= low_cnt + 32'd1;
            width_q     <= high_cnt;
            vld_pipe[0] <= fall & ~to_hit;
            to_pipe[0]  <= to_hit;
            vld_pipe[1] <= vld_pipe[0];
            to_pipe[1]  <= to_pipe[0];
            if (vld_pipe[0]) code_q <= classify(width_q);
        end
    end

    always_comb begin
        ev_sym = vld_pipe[STAGES];
        ev_to  = to_pipe[STAGES];
        is_p   = (code_q == CODE_P);
        is_bit = (code_q == CODE_0) || (code_q == CODE_1);
        idx_nx = (idx == 7'd99) ? 7'd0 : idx + 7'd1;
        marker = (idx_nx == 7'd0) || ((idx_nx % 7'd10) == 7'd9);
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        prev_p_n   = prev_p;
        sync_err_n = 1'b0;
        frame_done = 1'b0;
        cap_en     = 1'b0;
        clr_sh     = 1'b0;
        case (state)
            HUNT: if (ev_sym) begin
                if (is_p && prev_p) begin
                    state_n  = LOCKED;
                    idx_n    = 7'd0;
                    prev_p_n = 1'b0;
                    clr_sh   = 1'b1;
                end else begin
                    prev_p_n = is_p;
                end
            end
            LOCKED: if (ev_to) begin
                state_n    = HUNT;
                sync_err_n = 1'b1;
                prev_p_n   = 1'b0;
            end else if (ev_sym) begin
                if (marker ? !is_p : !is_bit) begin
                    state_n    = HUNT;
                    sync_err_n = 1'b1;
                    prev_p_n   = is_p;
                end else begin
                    idx_n      = idx_nx;
                    cap_en     = is_bit;
                    frame_done = (idx_nx == 7'd99);
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge pll_c0) begin
        if (rst) begin
            state  <= HUNT;
            idx    <= '0;
            prev_p <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            prev_p <= prev_p_n;
        end
    end

    assign locked = (state == LOCKED);

`ifdef IRIG_BCD_CHECK_EN
    function automatic logic bcd_ok(input irig_time_t t);
        logic [9:0] d;
        d = 10'(t.day[9:8]) * 10'd100 + 10'(t.day[7:4]) * 10'd10 + 10'(t.day[3:0]);
        return (t.sec[3:0] <= 4'd9) && (t.sec[6:4] <= 3'd5) &&
               (t.min[3:0] <= 4'd9) && (t.min[6:4] <= 3'd5) &&
               (t.hour[3:0] <= 4'd9) &&
               ((t.hour[5:4] <= 2'd1) || (t.hour[5:4] == 2'd2 && t.hour[3:0] <= 4'd3)) &&
               (t.day[3:0] <= 4'd9) && (t.day[7:4] <= 4'd9) &&
               (t.year[3:0] <= 4'd9) && (t.year[7:4] <= 4'd9) &&
               (d >= 10'd1) && (d <= 10'd366);
    endfunction

    always_comb frame_ok = bcd_ok(shadow);

    always_ff @(posedge pll_c0) begin
        if (rst) bcd_err <= 1'b0;
        else     bcd_err <= frame_done & ~frame_ok;
    end
`else
    assign frame_ok = 1'b1;
    assign bcd_err  = 1'b0;
`endif

    always_ff @(posedge pll_c0) begin
        if (rst) begin
            sym_valid   <= 1'b0;
            sym_code    <= CODE_X;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            shadow      <= '0;
            {sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} <= '0;
        end else begin
            sym_valid   <= ev_sym;
            if (ev_sym) sym_code <= code_q;
            sync_err    <= sync_err_n;
            frame_valid <= frame_done & frame_ok;
            if (frame_done & frame_ok)
                {sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} <= shadow;
            // Data symbols land in the shadow by frame position; unmapped positions are dropped.
            if (clr_sh) shadow <= '0;
            else if (cap_en) begin
                case (idx_nx) inside
                    [7'd1:7'd4]:   shadow.sec[3'(idx_nx - 7'd1)]   <= (code_q == CODE_1);
                    [7'd6:7'd8]:   shadow.sec[3'(idx_nx - 7'd2)]   <= (code_q == CODE_1);
                    [7'd10:7'd13]: shadow.min[3'(idx_nx - 7'd10)]  <= (code_q == CODE_1);
                    [7'd15:7'd17]: shadow.min[3'(idx_nx - 7'd11)]  <= (code_q == CODE_1);
                    [7'd20:7'd23]: shadow.hour[3'(idx_nx - 7'd20)] <= (code_q == CODE_1);
                    [7'd25:7'd26]: shadow.hour[3'(idx_nx - 7'd21)] <= (code_q == CODE_1);
                    [7'd30:7'd33]: shadow.day[4'(idx_nx - 7'd30)]  <= (code_q == CODE_1);
                    [7'd35:7'd38]: shadow.day[4'(idx_nx - 7'd31)]  <= (code_q == CODE_1);
                    [7'd40:7'd41]: shadow.day[4'(idx_nx - 7'd32)]  <= (code_q == CODE_1);
                    [7'd50:7'd53]: shadow.year[3'(idx_nx - 7'd50)] <= (code_q == CODE_1);
                    [7'd55:7'd58]: shadow.year[3'(idx_nx - 7'd51)] <= (code_q == CODE_1);
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_irig_b_decoder.sv
// Randomized bench for irig_b_decoder with time-scaled thresholds (1 ms -> 10 cycles).
module tb_irig_b_decoder;
    localparam int T1 = 10, T3 = 30, T4 = 40, T6 = 60, T7 = 70, T9 = 90, TO = 120;
    localparam int K0 = 0, K1 = 1, KP = 2;

    logic       pll_c0 = 1'b0, rst = 1'b1, b_code_in = 1'b0;
    logic       sym_valid, locked, frame_valid, sync_err, bcd_err;
    logic [7:0] sym_code, year_bcd;
    logic [6:0] sec_bcd, min_bcd;
    logic [5:0] hour_bcd;
    logic [9:0] day_bcd;

    irig_b_decoder #(.TH_1MS(T1), .TH_3MS(T3), .TH_4MS(T4), .TH_6MS(T6),
                     .TH_7MS(T7), .TH_9MS(T9), .TO_12MS(TO)) dut (
        .pll_c0(pll_c0), .rst(rst), .b_code_in(b_code_in),
        .sym_valid(sym_valid), .sym_code(sym_code), .locked(locked),
        .frame_valid(frame_valid), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
        .hour_bcd(hour_bcd), .day_bcd(day_bcd), .year_bcd(year_bcd),
        .sync_err(sync_err), .bcd_err(bcd_err));

    always #4 pll_c0 = ~pll_c0;

    typedef struct {
        logic [6:0] sec; logic [6:0] min; logic [5:0] hour; logic [9:0] day; logic [7:0] year;
    } tf_t;

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] sym_q[$];
    tf_t        fr_q[$];
    int         n_sync = 0, n_bcd = 0;
    int         fsym[100];

    always @(negedge pll_c0) begin
        if (sym_valid)   sym_q.push_back(sym_code);
        if (frame_valid) fr_q.push_back('{sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd});
        if (sync_err)    n_sync++;
        if (bcd_err)     n_bcd++;
    end

    // Reference: symbol class from the width rules.
    function automatic logic [7:0] ref_code(int w);
        if (w >= T1 && w <= T3) return 8'h30;
        if (w >= T4 && w <= T6) return 8'h31;
        if (w >= T7 && w <= T9) return 8'h70;
        return 8'h00;
    endfunction

    function automatic int to_bcd(int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10;
    endfunction

    function automatic void put(int pos, int val, int nbits);
        for (int b = 0; b < nbits; b++) fsym[pos + b] = (val >> b) & 1;
    endfunction

    // Frame as 100 symbol kinds; unused data slots get random bits.
    function automatic void make_frame(int sec, int mn, int hr, int day, int yr);
        for (int i = 0; i < 100; i++)
            fsym[i] = (i == 0 || i % 10 == 9) ? KP : int'($urandom % 2);
        put(1, sec % 10, 4);  put(6, sec / 10, 3);
        put(10, mn % 10, 4);  put(15, mn / 10, 3);
        put(20, hr % 10, 4);  put(25, hr / 10, 2);
        put(30, day % 10, 4); put(35, (day / 10) % 10, 4); put(40, day / 100, 2);
        put(50, yr % 10, 4);  put(55, yr / 10, 4);
    endfunction

    task automatic drive(logic v, int n);
        b_code_in = v;
        repeat (n) begin @(posedge pll_c0); #1; end
    endtask

    task automatic send(int kind);
        drive(1'b1, kind == KP ? 80 : (kind == K1 ? 50 : 20));
        drive(1'b0, 10);
    endtask

    task automatic send_range(int lo, int hi);
        for (int i = lo; i <= hi; i++) send(fsym[i]);
    endtask

    task automatic do_reset;
        rst = 1'b1; b_code_in = 1'b0;
        repeat (3) @(posedge pll_c0);
        #1 rst = 1'b0;
        @(posedge pll_c0); #1;
        sym_q.delete(); fr_q.delete(); n_sync = 0; n_bcd = 0;
    endtask

    task automatic test_reset;
        logic exp_v;
        do_reset();
        n_cmp++; if ({sym_valid, locked, frame_valid, sync_err, bcd_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 00000",
                              {sym_valid, locked, frame_valid, sync_err, bcd_err}); end
        n_cmp++; if ({sym_code, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} !== '0) begin
            n_bad++; $display("FAIL reset_fields: got %h expected 0",
                              {sym_code, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd}); end
        drive(1'b1, 80);
        b_code_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pll_c0); #1;
            exp_v = (i == 4);
            n_cmp++; if (sym_valid !== exp_v) begin
                n_bad++; $display("FAIL latency_edge%0d: got %b expected %b", i, sym_valid, exp_v); end
        end
        drive(1'b0, 10);
        n_cmp++; if (sym_code !== 8'h70) begin
            n_bad++; $display("FAIL first_p_code: got %h expected 70", sym_code); end
        n_cmp++; if (locked !== 1'b0) begin
            n_bad++; $display("FAIL lone_p_locked: got %b expected 0", locked); end
        send(KP);
        n_cmp++; if (locked !== 1'b1) begin
            n_bad++; $display("FAIL pp_locked: got %b expected 1", locked); end
    endtask

    task automatic test_width;
        int w[12] = '{9, 10, 30, 31, 70, 90, 39, 40, 60, 61, 69, 91};
        logic [7:0] got;
        do_reset();
        foreach (w[i]) begin drive(1'b1, w[i]); drive(1'b0, 10); end
        n_cmp++; if (sym_q.size() != 12) begin
            n_bad++; $display("FAIL width_count: got %0d expected 12", sym_q.size()); end
        foreach (w[i]) if (sym_q.size() > 0) begin
            got = sym_q.pop_front();
            n_cmp++; if (got !== ref_code(w[i])) begin
                n_bad++; $display("FAIL width_%0d: got %h expected %h", w[i], got, ref_code(w[i])); end
        end
    endtask

    task automatic test_random_symbols;
        int w[40];
        logic [7:0] got;
        do_reset();
        foreach (w[i]) begin
            w[i] = int'($urandom_range(1, 110));
            drive(1'b1, w[i]);
            drive(1'b0, int'($urandom_range(6, 30)));
        end
        n_cmp++; if (sym_q.size() != 40) begin
            n_bad++; $display("FAIL rand_count: got %0d expected 40", sym_q.size()); end
        foreach (w[i]) if (sym_q.size() > 0) begin
            got = sym_q.pop_front();
            n_cmp++; if (got !== ref_code(w[i])) begin
                n_bad++; $display("FAIL rand_w%0d: got %h expected %h", w[i], got, ref_code(w[i])); end
        end
    endtask

    task automatic test_frame;
        tf_t f;
        do_reset();
        send(KP); send(KP);
        n_cmp++; if (locked !== 1'b1) begin
            n_bad++; $display("FAIL frame_lock: got %b expected 1", locked); end
        make_frame(12, 34, 5, 123, 24);
        send_range(1, 99);
        n_cmp++; if (fr_q.size() != 1 || n_sync != 0) begin
            n_bad++; $display("FAIL frame_count: got %0d/%0d expected 1/0", fr_q.size(), n_sync); end
        if (fr_q.size() > 0) begin
            f = fr_q.pop_front();
            n_cmp++; if ({f.sec, f.min, f.hour, f.day, f.year} !== {7'h12, 7'h34, 6'h05, 10'h123, 8'h24}) begin
                n_bad++; $display("FAIL frame_fields: got %h %h %h %h %h expected 12 34 05 123 24",
                                  f.sec, f.min, f.hour, f.day, f.year); end
        end
    endtask

    task automatic test_back_to_back;
        int v[2][5];
        tf_t f;
        do_reset();
        send(KP);
        for (int k = 0; k < 2; k++) begin
            v[k] = '{int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
                     int'($urandom_range(0, 23)), int'($urandom_range(1, 366)), int'($urandom_range(0, 99))};
            make_frame(v[k][0], v[k][1], v[k][2], v[k][3], v[k][4]);
            send_range(0, 99);
        end
        n_cmp++; if (fr_q.size() != 2 || locked !== 1'b1) begin
            n_bad++; $display("FAIL b2b_count: got %0d locked %b expected 2 locked 1", fr_q.size(), locked); end
        for (int k = 0; k < 2; k++) if (fr_q.size() > 0) begin
            f = fr_q.pop_front();
            n_cmp++; if ({f.sec, f.min, f.hour, f.day, f.year} !== {7'(to_bcd(v[k][0])), 7'(to_bcd(v[k][1])),
                         6'(to_bcd(v[k][2])), 10'(to_bcd(v[k][3])), 8'(to_bcd(v[k][4]))}) begin
                n_bad++; $display("FAIL b2b_frame%0d: got %h %h %h %h %h expected %0d %0d %0d %0d %0d", k,
                                  f.sec, f.min, f.hour, f.day, f.year, v[k][0], v[k][1], v[k][2], v[k][3], v[k][4]); end
        end
    endtask

    task automatic test_marker_error;
        do_reset();
        send(KP);
        make_frame(12, 34, 5, 123, 24);
        send_range(0, 99);
        make_frame(45, 1, 2, 3, 4);
        send_range(0, 18);
        send(K0);
        n_cmp++; if (n_sync != 1 || locked !== 1'b0) begin
            n_bad++; $display("FAIL marker_sync: got %0d pulses locked %b expected 1 locked 0", n_sync, locked); end
        n_cmp++; if (fr_q.size() != 1) begin
            n_bad++; $display("FAIL marker_frames: got %0d expected 1", fr_q.size()); end
        n_cmp++; if ({sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} !== {7'h12, 7'h34, 6'h05, 10'h123, 8'h24}) begin
            n_bad++; $display("FAIL marker_hold: got %h %h %h %h %h expected 12 34 05 123 24",
                              sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd); end
    endtask

    task automatic test_timeout_and_rst;
        do_reset();
        send(KP); send(KP); send(K1); send(K0);
        drive(1'b0, 200);
        n_cmp++; if (n_sync != 1 || locked !== 1'b0) begin
            n_bad++; $display("FAIL timeout_sync: got %0d pulses locked %b expected 1 locked 0", n_sync, locked); end
        send(KP);
        make_frame(7, 8, 9, 10, 11);
        send_range(0, 99);
        send_range(0, 4);
        n_cmp++; if (fr_q.size() != 1 || sec_bcd !== 7'h07 || locked !== 1'b1) begin
            n_bad++; $display("FAIL pre_rst: got %0d frames sec %h locked %b expected 1 07 1",
                              fr_q.size(), sec_bcd, locked); end
        rst = 1'b1;
        @(posedge pll_c0); #1;
        n_cmp++; if ({sym_valid, locked, frame_valid, sync_err, bcd_err, sym_code,
                      sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} !== '0) begin
            n_bad++; $display("FAIL mid_rst: got %h expected 0", {sym_valid, locked, frame_valid, sync_err,
                              bcd_err, sym_code, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd}); end
        rst = 1'b0;
    endtask

    task automatic test_bcd;
        do_reset();
        send(KP);
        make_frame(65, 34, 5, 123, 24);
        send_range(0, 99);
`ifdef IRIG_BCD_CHECK_EN
        n_cmp++; if (n_bcd != 1 || fr_q.size() != 0 || locked !== 1'b1) begin
            n_bad++; $display("FAIL bcd_check: got bcd %0d frames %0d locked %b expected 1 0 1",
                              n_bcd, fr_q.size(), locked); end
        n_cmp++; if (sec_bcd !== 7'h00) begin
            n_bad++; $display("FAIL bcd_hold: got %h expected 00", sec_bcd); end
`else
        n_cmp++; if (n_bcd != 0 || fr_q.size() != 1 || locked !== 1'b1) begin
            n_bad++; $display("FAIL bcd_nocheck: got bcd %0d frames %0d locked %b expected 0 1 1",
                              n_bcd, fr_q.size(), locked); end
        n_cmp++; if (sec_bcd !== 7'h65) begin
            n_bad++; $display("FAIL bcd_sec: got %h expected 65", sec_bcd); end
`endif
    endtask

    initial begin
        test_reset();
        test_width();
        test_random_symbols();
        test_frame();
        test_back_to_back();
        test_marker_error();
        test_timeout_and_rst();
        test_bcd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
